// File: rtl/hash_request_sequencer.sv
// One-at-a-time request sequencer in front of the hash-table controller: hash, table read, exec, held response.
// Accept-to-response latency is 3+READ_LATENCY cycles; new requests stall until the response handshake completes.
module hash_request_sequencer #(
  parameter int KEY_WIDTH           = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 8,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            req_valid_i,
  output logic                                            req_ready_o,
  input  logic [1:0]                                      req_op_i,
  input  logic [KEY_WIDTH-1:0]                            req_key_i,
  input  logic [DATA_WIDTH-1:0]                           req_data_i,
  output logic                                            tbl_rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] tbl_rd_adr_o,
  output logic [KEY_WIDTH-1:0]                            ctrl_key_o,
  output logic [DATA_WIDTH-1:0]                           ctrl_data_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] ctrl_hash_adr_o,
  output logic [1:0]                                      ctrl_op_o,
  output logic                                            ctrl_clk_en_o,
  input  logic [DATA_WIDTH-1:0]                           ctrl_read_data_i,
  input  logic                                            ctrl_no_deletion_target_i,
  input  logic                                            ctrl_no_write_space_i,
  input  logic                                            ctrl_no_element_found_i,
  input  logic                                            ctrl_key_already_present_i,
  output logic                                            rsp_valid_o,
  input  logic                                            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                           rsp_data_o,
  output logic [2:0]                                      rsp_status_o
);
  localparam int A      = HASH_TABLE_MAX_SIZE;
  localparam int N      = NUMBER_OF_TABLES;
  localparam int SLICES = (KEY_WIDTH + A - 1) / A;
  localparam int CW     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HASH, S_READ, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [A*N-1:0]          hash_q, hash_d;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [2:0]              rsp_status_q, rsp_status_d;
  logic [A-1:0]            fold;

  function automatic logic [A-1:0] fold_key(input logic [KEY_WIDTH-1:0] key);
    logic [SLICES*A-1:0] padded;
    logic [A-1:0]        acc;
    padded = '0;
    padded[KEY_WIDTH-1:0] = key;
    acc = '0;
    for (int s = 0; s < SLICES; s++) acc ^= padded[s*A +: A];
    return acc;
  endfunction

  assign fold = fold_key(key_q);

  // Per-table salt and rotation decorrelate the buckets of a single folded key.
  for (genvar t = 0; t < N; t++) begin : g_hash
    localparam int          ROT  = t % A;
    localparam logic [31:0] SALT = 32'(t) * 32'h5B;
    logic [A-1:0]   mixed;
    logic [2*A-1:0] dbl;
    assign mixed = fold ^ SALT[A-1:0];
    assign dbl   = {mixed, mixed};
    assign hash_d[t*A +: A] = dbl[2*A-1-ROT -: A];
  end

  always_comb begin
    rsp_status_d = 3'd0;
    rsp_data_d   = '0;
    case (op_q)
      2'b01: begin
        rsp_status_d = ctrl_no_element_found_i ? 3'd1 : 3'd0;
        rsp_data_d   = ctrl_no_element_found_i ? '0 : ctrl_read_data_i;
      end
      2'b10: begin
        if (ctrl_key_already_present_i) rsp_status_d = 3'd4;
        else if (ctrl_no_write_space_i) rsp_status_d = 3'd3;
      end
      2'b11: rsp_status_d = ctrl_no_deletion_target_i ? 3'd2 : 3'd0;
      default: rsp_status_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      key_q        <= '0;
      data_q       <= '0;
      hash_q       <= '0;
      cnt          <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid_i) begin
        op_q   <= req_op_i;
        key_q  <= req_key_i;
        data_q <= req_data_i;
      end
      if (state == S_HASH) hash_q <= hash_d;
      if (state == S_READ) cnt <= CW'(READ_LATENCY - 1);
      else if (state == S_WAIT) cnt <= cnt - 1'b1;
      if (state == S_EXEC) begin
        rsp_data_q   <= rsp_data_d;
        rsp_status_q <= rsp_status_d;
      end else if (state == S_RESP && rsp_ready_i) begin
        rsp_data_q   <= '0;
        rsp_status_q <= '0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready_o   = 1'b0;
    tbl_rd_en_o   = 1'b0;
    ctrl_op_o     = 2'b00;
    ctrl_clk_en_o = 1'b0;
    rsp_valid_o   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = S_HASH;
      end
      S_HASH: state_nxt = S_READ;
      S_READ: begin
        tbl_rd_en_o = 1'b1;
        state_nxt   = (READ_LATENCY == 1) ? S_EXEC : S_WAIT;
      end
      // cnt is the value before this cycle's decrement, so 1 means it hits zero now.
      S_WAIT: if (cnt == CW'(1)) state_nxt = S_EXEC;
      S_EXEC: begin
        ctrl_op_o     = op_q;
        ctrl_clk_en_o = 1'b1;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      req_ready_o   = 1'b0;
      tbl_rd_en_o   = 1'b0;
      ctrl_op_o     = 2'b00;
      ctrl_clk_en_o = 1'b0;
      rsp_valid_o   = 1'b0;
    end
  end

  assign tbl_rd_adr_o    = hash_q;
  assign ctrl_hash_adr_o = hash_q;
  assign ctrl_key_o      = key_q;
  assign ctrl_data_o     = data_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_status_o    = rsp_status_q;

endmodule

// File: tb/tb_hash_request_sequencer.sv
// Directed bench: one instance with READ_LATENCY=1 for function/timing, one with READ_LATENCY=3 for mid-wait reset.
module tb_hash_request_sequencer;
  logic        clk = 1'b0;
  logic        reset1, reset3, req_valid1, req_valid3;
  logic [1:0]  req_op;
  logic [31:0] req_key, req_data, ctrl_read_data;
  logic [3:0]  flg;  // {key_already_present, no_write_space, no_element_found, no_deletion_target}
  logic        rsp_ready;

  logic        ready1, rd_en1, clk_en1, rsp_valid1;
  logic [23:0] rd_adr1, hash_adr1;
  logic [31:0] ctrl_key1, ctrl_data1, rsp_data1;
  logic [1:0]  ctrl_op1;
  logic [2:0]  status1;

  logic        ready3, rd_en3, clk_en3, rsp_valid3;
  logic [23:0] rd_adr3, hash_adr3;
  logic [31:0] ctrl_key3, ctrl_data3, rsp_data3;
  logic [1:0]  ctrl_op3;
  logic [2:0]  status3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hash_request_sequencer #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .req_valid_i(req_valid1), .req_ready_o(ready1), .req_op_i(req_op),
    .req_key_i(req_key), .req_data_i(req_data),
    .tbl_rd_en_o(rd_en1), .tbl_rd_adr_o(rd_adr1),
    .ctrl_key_o(ctrl_key1), .ctrl_data_o(ctrl_data1), .ctrl_hash_adr_o(hash_adr1),
    .ctrl_op_o(ctrl_op1), .ctrl_clk_en_o(clk_en1), .ctrl_read_data_i(ctrl_read_data),
    .ctrl_no_deletion_target_i(flg[0]), .ctrl_no_write_space_i(flg[2]),
    .ctrl_no_element_found_i(flg[1]), .ctrl_key_already_present_i(flg[3]),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data1), .rsp_status_o(status1)
  );

  hash_request_sequencer #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .req_valid_i(req_valid3), .req_ready_o(ready3), .req_op_i(req_op),
    .req_key_i(req_key), .req_data_i(req_data),
    .tbl_rd_en_o(rd_en3), .tbl_rd_adr_o(rd_adr3),
    .ctrl_key_o(ctrl_key3), .ctrl_data_o(ctrl_data3), .ctrl_hash_adr_o(hash_adr3),
    .ctrl_op_o(ctrl_op3), .ctrl_clk_en_o(clk_en3), .ctrl_read_data_i(ctrl_read_data),
    .ctrl_no_deletion_target_i(flg[0]), .ctrl_no_write_space_i(flg[2]),
    .ctrl_no_element_found_i(flg[1]), .ctrl_key_already_present_i(flg[3]),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data3), .rsp_status_o(status3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full transaction on the READ_LATENCY=1 instance, accept at cycle 0, response at cycle 4.
  task automatic do_req1(input string nm, input logic [1:0] op, input logic [31:0] key, data, rdat,
                         input logic [3:0] f, input logic [23:0] ehash,
                         input logic [2:0] est, input logic [31:0] edat);
    rsp_ready = 1'b1; req_op = op; req_key = key; req_data = data;
    ctrl_read_data = rdat; flg = f;
    chk({nm, ".rdy_c0"}, ready1, 1);
    req_valid1 = 1'b1;
    tick(); req_valid1 = 1'b0;
    chk({nm, ".rdy_c1"}, ready1, 0);
    chk({nm, ".op_c1"}, ctrl_op1, 0);
    tick();
    chk({nm, ".rd_en_c2"}, rd_en1, 1);
    chk({nm, ".rd_adr"}, rd_adr1, ehash);
    chk({nm, ".hash_adr"}, hash_adr1, ehash);
    chk({nm, ".op_c2"}, ctrl_op1, 0);
    tick();
    chk({nm, ".op_exec"}, ctrl_op1, op);
    chk({nm, ".clk_en_exec"}, clk_en1, 1);
    chk({nm, ".key_exec"}, ctrl_key1, key);
    chk({nm, ".data_exec"}, ctrl_data1, data);
    chk({nm, ".rd_en_c3"}, rd_en1, 0);
    tick();
    chk({nm, ".rsp_vld"}, rsp_valid1, 1);
    chk({nm, ".rsp_dat"}, rsp_data1, edat);
    chk({nm, ".rsp_st"}, status1, est);
    chk({nm, ".op_c4"}, ctrl_op1, 0);
    chk({nm, ".clk_en_c4"}, clk_en1, 0);
    tick();
    chk({nm, ".vld_c5"}, rsp_valid1, 0);
    chk({nm, ".rdy_c5"}, ready1, 1);
  endtask

  initial begin
    logic bad;
    reset1 = 1'b1; reset3 = 1'b1; req_valid1 = 1'b0; req_valid3 = 1'b0;
    req_op = 2'b00; req_key = '0; req_data = '0; ctrl_read_data = '0; flg = '0; rsp_ready = 1'b0;

    repeat (3) tick();
    chk("rst.zero1", |{ready1, rd_en1, rd_adr1, ctrl_key1, ctrl_data1, hash_adr1, ctrl_op1,
                       clk_en1, rsp_valid1, rsp_data1, status1}, 0);
    chk("rst.zero3", |{ready3, rd_en3, rd_adr3, ctrl_key3, ctrl_data3, hash_adr3, ctrl_op3,
                       clk_en3, rsp_valid3, rsp_data3, status3}, 0);
    reset1 = 1'b0;
    tick();
    chk("rst.rdy_after", ready1, 1);
    chk("rst.vld_after", rsp_valid1, 0);

    do_req1("rd_hit",   2'b01, 32'h0000_00FF, 32'h0,         32'hDEAD_BEEF, 4'b0000, 24'h2549FF, 3'd0, 32'hDEAD_BEEF);
    do_req1("rd_miss",  2'b01, 32'h0000_0000, 32'h0,         32'h1111_1111, 4'b0010, 24'hDAB600, 3'd1, 32'h0);
    do_req1("wr_kap",   2'b10, 32'h0102_0304, 32'h55AA_55AA, 32'h1234_5678, 4'b1100, 24'hCABE04, 3'd4, 32'h0);
    do_req1("wr_nws",   2'b10, 32'h0102_0304, 32'h55AA_55AA, 32'h1234_5678, 4'b0100, 24'hCABE04, 3'd3, 32'h0);
    do_req1("del_miss", 2'b11, 32'h8000_0001, 32'h0,         32'h0000_9999, 4'b0001, 24'hDCB581, 3'd2, 32'h0);
    do_req1("del_ok",   2'b11, 32'h8000_0001, 32'h0,         32'h0000_9999, 4'b0000, 24'hDCB581, 3'd0, 32'h0);
    do_req1("nop",      2'b00, 32'hA5A5_A5A5, 32'h7,         32'hABCD_EF01, 4'b1111, 24'hDAB600, 3'd0, 32'h0);
    do_req1("wr_ok",    2'b10, 32'h0000_00FF, 32'h3,         32'hABCD_EF01, 4'b0011, 24'h2549FF, 3'd0, 32'h0);

    // Held response under backpressure with a second request already waiting.
    rsp_ready = 1'b0; req_op = 2'b01; req_key = 32'h0000_00FF; req_data = '0;
    ctrl_read_data = 32'hCAFE_F00D; flg = 4'b0000;
    req_valid1 = 1'b1;
    tick();
    req_op = 2'b10; req_key = 32'h1234_5678; req_data = 32'h0BAD_F00D;
    repeat (3) tick();
    ctrl_read_data = 32'h0; flg = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("bp.vld", rsp_valid1, 1);
      chk("bp.dat", rsp_data1, 32'hCAFE_F00D);
      chk("bp.st", status1, 0);
      chk("bp.rdy", ready1, 0);
    end
    rsp_ready = 1'b1; flg = 4'b0000; ctrl_read_data = 32'h7777_7777;
    tick();
    chk("bp.vld_done", rsp_valid1, 0);
    chk("bp.rdy_done", ready1, 1);
    tick(); req_valid1 = 1'b0;
    chk("bp2.rdy_hash", ready1, 0);
    chk("bp2.key", ctrl_key1, 32'h1234_5678);
    chk("bp2.data", ctrl_data1, 32'h0BAD_F00D);
    repeat (2) tick();
    chk("bp2.op_exec", ctrl_op1, 2'b10);
    tick();
    chk("bp2.rsp_vld", rsp_valid1, 1);
    chk("bp2.rsp_dat", rsp_data1, 32'h0);
    chk("bp2.rsp_st", status1, 0);
    tick();

    // Reset during WAIT on the READ_LATENCY=3 instance.
    reset1 = 1'b1; reset3 = 1'b0;
    tick();
    chk("r3.rdy", ready3, 1);
    req_op = 2'b01; req_key = 32'h0000_00FF; flg = 4'b0000; ctrl_read_data = 32'h5555_AAAA;
    req_valid3 = 1'b1;
    tick(); req_valid3 = 1'b0;
    tick();
    chk("r3.rd_en", rd_en3, 1);
    tick();
    chk("r3.wait_op", ctrl_op3, 0);
    chk("r3.wait_rd_en", rd_en3, 0);
    reset3 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) reset3 = 1'b0;
      bad = bad | rsp_valid3 | clk_en3 | (ctrl_op3 != 2'b00);
    end
    chk("r3.aborted", bad, 0);
    chk("r3.rdy_after", ready3, 1);

    req_op = 2'b10; req_key = 32'h0102_0304; req_data = 32'hFEED_0001; flg = 4'b0100;
    req_valid3 = 1'b1;
    tick(); req_valid3 = 1'b0;
    tick();
    chk("r3n.rd_en", rd_en3, 1);
    chk("r3n.rd_adr", rd_adr3, 24'hCABE04);
    tick();
    chk("r3n.op_w1", ctrl_op3, 0);
    tick();
    chk("r3n.op_w2", ctrl_op3, 0);
    tick();
    chk("r3n.op_exec", ctrl_op3, 2'b10);
    chk("r3n.clk_en", clk_en3, 1);
    tick();
    chk("r3n.rsp_vld", rsp_valid3, 1);
    chk("r3n.rsp_st", status3, 3'd3);
    chk("r3n.rsp_dat", rsp_data3, 32'h0);
    tick();
    chk("r3n.vld_done", rsp_valid3, 0);
    chk("r3n.rdy_done", ready3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hash_request_sequencer.md
# hash_request_sequencer

Front-end stage placed directly upstream of the hash-table controller. It accepts host requests (read/write/delete) over a valid/ready handshake and computes one bucket address per table. It issues the table read-out, waits out the memory read latency, then drives the operation into the controller for exactly one cycle. It captures the controller's result flags and read data into a held response. Only one operation is in flight at a time, so the controller never sees a read-after-write hazard.

## Interface
Parameters:
- KEY_WIDTH, 32, key width in bits
- DATA_WIDTH, 32, payload width in bits
- NUMBER_OF_TABLES, 3, number of hash tables (≥2)
- HASH_TABLE_MAX_SIZE, 8, bucket address width A in bits
- READ_LATENCY, 1, cycles from table read enable to valid read-out at the controller inputs (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  2  00 nothing, 01 read, 10 write, 11 delete
- req_key_i  in  KEY_WIDTH  request key
- req_data_i  in  DATA_WIDTH  write payload
- tbl_rd_en_o  out  1  table read strobe
- tbl_rd_adr_o  out  A × NUMBER_OF_TABLES  per-table read address
- ctrl_key_o  out  KEY_WIDTH  key to controller
- ctrl_data_o  out  DATA_WIDTH  data to controller
- ctrl_hash_adr_o  out  A × NUMBER_OF_TABLES  hash addresses to controller
- ctrl_op_o  out  2  controller operation code
- ctrl_clk_en_o  out  1  controller clock enable
- ctrl_read_data_i  in  DATA_WIDTH  controller read data
- ctrl_no_deletion_target_i, ctrl_no_write_space_i, ctrl_no_element_found_i, ctrl_key_already_present_i  in  1 each  controller result flags
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  DATA_WIDTH  read result
- rsp_status_o  out  3  completion status

## Operation
- FSM states: IDLE → HASH → READ → WAIT → EXEC → RESP → IDLE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, register op/key/data and go to HASH.
- HASH:
  - Compute and register h_t for every table t.
  - fold(key) = XOR of all A-bit slices of the key; the last slice is zero-padded.
  - h_t = rotl_A(fold ^ ((t·8'h5B) mod 2^A), t mod A).
- READ:
  - tbl_rd_en_o=1 for one cycle.
  - tbl_rd_adr_o[t]=h_t.
- WAIT:
  - Down-counter loaded with READ_LATENCY−1; exit to EXEC when it reaches 0.
  - When READ_LATENCY=1, WAIT lasts 0 cycles (READ goes straight to EXEC).
- EXEC:
  - ctrl_op_o = registered op and ctrl_clk_en_o=1 for exactly one cycle.
  - Flags and read data are sampled at the end of this cycle.
- Status encoding, qualified by op:
  - read: no_element_found → 1, else 0.
  - delete: no_deletion_target → 2, else 0.
  - write: key_already_present → 4 (priority), else no_write_space → 3, else 0.
  - op 00: 0.
- rsp_data_o = ctrl_read_data_i for a successful read, else 0.
- RESP: rsp_valid_o=1. Data and status are held stable until rsp_ready_i. Then go to IDLE.
- Op 00 takes the full path with ctrl_op_o=00, so every accepted request produces exactly one response.
- ctrl_key_o, ctrl_data_o and ctrl_hash_adr_o are held from the registers from HASH+1 through RESP.
- ctrl_op_o=00 and ctrl_clk_en_o=0 in every state except EXEC.

## Timing
- Reset values:
  - FSM enters IDLE; all registers are cleared.
  - req_ready_o is 0 during reset and 1 from the first cycle after reset is released.
  - All other outputs are 0.
- Latency, with accept at cycle 0: HASH at 1, READ at 2, EXEC at 2+READ_LATENCY, rsp_valid_o at 3+READ_LATENCY (4 when READ_LATENCY=1).
- Minimum request spacing is 4+READ_LATENCY cycles when rsp_ready_i is held high.
- req_ready_o is 0 from cycle 1 until the cycle after the response handshake. Requests are never accepted while a response is pending.
- Reset at any point mid-operation aborts it: no response is produced, no EXEC is issued, and ctrl_op_o stays 00.
- Status flags are don't-care outside EXEC.

## Test plan
- Reset: pulse reset 3 cycles → all outputs 0 during reset; req_ready_o=1 on the first cycle after release; rsp_valid_o=0.
- Hash (A=8, N=3): key 0x000000FF → during READ, tbl_rd_adr_o = {0xFF, 0x49, 0x25} for t=0,1,2; ctrl_hash_adr_o matches.
- Read hit (READ_LATENCY=1):
  - Stimulus: op 01 accepted at cycle 0; ctrl_read_data_i=0xDEADBEEF, all flags 0.
  - Response: ctrl_op_o=01 only at cycle 3; rsp_valid_o at cycle 4 with rsp_data_o=0xDEADBEEF, status 0.
- Write conflict: op 10 with key_already_present=1 and no_write_space=1 in EXEC → status 4, rsp_data_o=0. Repeat with only no_write_space=1 → status 3.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with a second request pending → rsp_valid_o, data and status stay stable; req_ready_o=0; the second request is accepted only after the handshake.
- Reset during WAIT (READ_LATENCY=3): assert reset in WAIT → no rsp_valid_o, ctrl_op_o never leaves 00; a new request afterwards completes normally.
